// File: rtl/axil_array.sv
// Word-addressed memory behind an AXI-Lite-like slave: AR/R read path and AW+W/B write path,
// each a single-entry response register so both paths can stream one beat per cycle.
module axil_array #(
  parameter int N  = 1024,
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] araddr,
  input  logic          arvalid,
  output logic          arready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  input  logic          rready,
  input  logic [AW-1:0] awaddr,
  input  logic          awvalid,
  output logic          awready,
  input  logic [DW-1:0] wdata,
  input  logic          wvalid,
  output logic          wready,
  output logic          bvalid,
  input  logic          bready
);

  localparam bit Pow2 = (N == (1 << AW));

  logic [DW-1:0] mem_q [N];

  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          bvalid_q, bvalid_d;

  logic          arHs;
  logic          wrHs;

  // With a power-of-two depth the address already is the index; otherwise fold it into range.
  function automatic logic [AW-1:0] wrapIdx(input logic [AW-1:0] a);
    if (Pow2) begin
      return a;
    end else begin
      return AW'(32'(a) % 32'(N));
    end
  endfunction

  assign arready = !rvalid_q || rready;
  assign arHs    = arvalid && arready;

  // Address and data are only ever taken together, and only when the B slot is free or draining.
  assign wrHs    = awvalid && wvalid && (!bvalid_q || bready);
  assign awready = wrHs;
  assign wready  = wrHs;

  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign bvalid  = bvalid_q;

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    bvalid_d = bvalid_q;

    if (arHs) begin
      rvalid_d = 1'b1;
      rdata_d  = mem_q[wrapIdx(araddr)];
    end else if (rready) begin
      rvalid_d = 1'b0;
    end

    if (wrHs) begin
      bvalid_d = 1'b1;
    end else if (bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      bvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      bvalid_q <= bvalid_d;
    end
  end

  // Storage is never cleared; a write coinciding with reset is suppressed.
  // The read above samples mem_q before this update lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!rst && wrHs) begin
      mem_q[wrapIdx(awaddr)] <= wdata;
    end
  end

endmodule

// File: tb/tb_axil_array.sv
// Self-checking bench for axil_array: directed scenarios plus seeded random traffic,
// compared against an array-based reference of the memory and its response slots.
module tb_axil_array;

  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  logic          bvalid;
  logic          bready;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] refMem   [N];
  bit            refKnown [N];
  bit            expRv;
  bit            expBv;
  logic [DW-1:0] expRd;
  bit            rdKnown;
  int            rBeats;
  int            bBeats;
  bit            ah;
  bit            wh;

  axil_array #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: check the ready outputs, advance the reference, then check the responses.
  task automatic applyStimulus(input bit arv, input logic [AW-1:0] ara,
                               input bit awv, input logic [AW-1:0] awa,
                               input bit wv, input logic [DW-1:0] wd,
                               input bit rr, input bit br,
                               output bit arHs, output bit wHs);
    bit expAr;
    bit expW;
    arvalid = arv; araddr = ara;
    awvalid = awv; awaddr = awa;
    wvalid  = wv;  wdata  = wd;
    rready  = rr;  bready = br;
    #1;
    expAr = !expRv || rr;
    expW  = awv && wv && (!expBv || br);
    checkOutput("arready", DW'(arready), DW'(expAr));
    checkOutput("awready", DW'(awready), DW'(expW));
    checkOutput("wready",  DW'(wready),  DW'(expW));
    if (rvalid && rr) rBeats++;
    if (bvalid && br) bBeats++;
    arHs = arv && expAr;
    wHs  = expW;
    if (arHs) begin
      expRd   = refMem[int'(ara) % N];
      rdKnown = refKnown[int'(ara) % N];
      expRv   = 1'b1;
    end else if (rr) begin
      expRv = 1'b0;
    end
    if (wHs) begin
      refMem[int'(awa) % N]   = wd;
      refKnown[int'(awa) % N] = 1'b1;
      expBv = 1'b1;
    end else if (br) begin
      expBv = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("rvalid", DW'(rvalid), DW'(expRv));
    checkOutput("bvalid", DW'(bvalid), DW'(expBv));
    if (expRv && rdKnown) checkOutput("rdata", rdata, expRd);
  endtask

  task automatic idle();
    applyStimulus(0, '0, 0, '0, 0, '0, 1, 1, ah, wh);
  endtask

  task automatic readBack(input logic [AW-1:0] a);
    applyStimulus(1, a, 0, '0, 0, '0, 1, 1, ah, wh);
  endtask

  // Reset with every valid raised and a write aimed at address 7; none of it may take effect.
  task automatic applyReset(input int cycles);
    rst = 1'b1;
    arvalid = 1'b1; araddr = 10'd3;
    awvalid = 1'b1; awaddr = 10'd7;
    wvalid  = 1'b1; wdata  = 32'hDEAD_BEEF;
    rready  = 1'b0; bready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    expRv = 1'b0; expBv = 1'b0; expRd = '0; rdKnown = 1'b1;
    checkOutput("rst_rvalid", DW'(rvalid), '0);
    checkOutput("rst_bvalid", DW'(bvalid), '0);
    checkOutput("rst_rdata",  rdata, '0);
  endtask

  initial begin
    int snap;
    int wi;
    int ri;
    int cyc;
    int base;
    bit arv;
    bit awv;
    bit wv;
    foreach (refKnown[i]) refKnown[i] = 1'b0;
    rBeats = 0; bBeats = 0;
    applyReset(2);

    $display("[TB] fill and readback");
    for (int i = 0; i < N; i++) applyStimulus(0, '0, 1, AW'(i), 1, DW'(i), 1, 1, ah, wh);
    idle();
    checkOutput("fill_b_beats", DW'(bBeats), DW'(N));
    for (int i = 0; i < N; i++) readBack(AW'(i));
    idle();
    checkOutput("read_r_beats", DW'(rBeats), DW'(N));

    $display("[TB] collision and top address");
    applyStimulus(0, '0, 1, 10'd5, 1, 32'd7, 1, 1, ah, wh);
    applyStimulus(1, 10'd5, 1, 10'd5, 1, 32'd9, 1, 1, ah, wh);
    checkOutput("collision_old", rdata, 32'd7);
    readBack(10'd5);
    checkOutput("collision_new", rdata, 32'd9);
    applyStimulus(0, '0, 1, 10'd1023, 1, 32'hCAFE_0001, 1, 1, ah, wh);
    readBack(10'd1023);
    idle();

    $display("[TB] read backpressure");
    applyStimulus(1, 10'd10, 0, '0, 0, '0, 0, 1, ah, wh);
    for (int i = 0; i < 4; i++) applyStimulus(1, 10'd11, 0, '0, 0, '0, 0, 1, ah, wh);
    checkOutput("rd_hold", rdata, 32'd10);
    applyStimulus(1, 10'd11, 0, '0, 0, '0, 1, 1, ah, wh);
    checkOutput("rd_release", rdata, 32'd11);
    idle();

    $display("[TB] write backpressure");
    applyStimulus(0, '0, 1, 10'd20, 1, 32'hAAAA, 1, 0, ah, wh);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 1, 10'd21, 1, 32'hBBBB, 1, 0, ah, wh);
    applyStimulus(0, '0, 0, '0, 0, '0, 1, 1, ah, wh);
    readBack(10'd21);
    checkOutput("wr_stall_nowrite", rdata, 32'd21);
    readBack(10'd20);
    idle();

    $display("[TB] split write channels");
    snap = bBeats;
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 1, 10'd30, 0, 32'h5555, 1, 1, ah, wh);
    applyStimulus(0, '0, 1, 10'd30, 1, 32'h1234, 1, 1, ah, wh);
    idle();
    idle();
    checkOutput("split_b_beats", DW'(bBeats - snap), 32'd1);
    readBack(10'd30);
    checkOutput("split_data", rdata, 32'h1234);
    idle();

    $display("[TB] reset with responses pending");
    applyStimulus(1, 10'd40, 1, 10'd41, 1, 32'h4141, 0, 0, ah, wh);
    applyReset(2);
    readBack(10'd7);
    checkOutput("rst_nowrite", rdata, 32'd7);
    readBack(10'd41);
    idle();

    // Random traffic: 64 sequential writes per seed with independent AW/W bubbles, random reads anywhere.
    for (int s = 0; s < 2; s++) begin
      void'($urandom(s == 0 ? 21 : 42));
      $display("[TB] random traffic seed %0d", s == 0 ? 21 : 42);
      base = (s == 0) ? 400 : 600;
      wi = 0; ri = 0; cyc = 0;
      while ((wi < 64 || ri < 64) && cyc < 3000) begin
        arv = ($urandom_range(0, 3) != 0) && (ri < 64);
        awv = ($urandom_range(0, 2) != 0) && (wi < 64);
        wv  = ($urandom_range(0, 2) != 0) && (wi < 64);
        applyStimulus(arv, AW'($urandom_range(0, N - 1)),
                      awv, AW'(base + wi), wv, $urandom(),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ah, wh);
        if (ah) ri++;
        if (wh) wi++;
        cyc++;
      end
      idle();
      checkOutput("rand_writes_done", DW'(wi), 32'd64);
      checkOutput("rand_reads_done",  DW'(ri), 32'd64);
      for (int i = 0; i < 64; i++) readBack(AW'(base + i));
      idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
